tmr_scrub_ctrl: RTL and testbench

Scrub controller for a triplicated register bank with copies A/B/C.
- Periodically, or on request, walks every bank address and reads all three copies.
- Majority-votes each word and writes the voted word back when the copies disagree.
- Keeps error statistics.
- Functional (user) accesses to the bank always have priority; the scrubber stalls around them.

---
 rtl/tmr_scrub_pkg.sv | 20 ++
 rtl/tmr_majority_voter.sv | 16 +
 rtl/tmr_scrub_ctrl.sv | 133 +++++++++++++
 tb/tb_tmr_scrub_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_scrub_pkg.sv
// Shared types for the TMR scrub controller: FSM state encoding, error counter
// width and the saturating increment used by the statistics logic.
package tmr_scrub_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    VOTE,
    WRITE,
    NEXT,
    DONE
  } scrub_state_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/tmr_majority_voter.sv
// Bitwise 2-of-3 majority voter for triplicated words; purely combinational.
// mismatch flags any disagreement between the three copies.
module tmr_majority_voter #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] voted,
  output logic              mismatch
);

  assign voted    = (a & b) | (b & c) | (a & c);
  assign mismatch = (a != b) || (b != c);

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Scrubber for an A/B/C triplicated bank: walks every address, votes the three
// copies and rewrites disagreeing words, yielding to functional accesses.
module tmr_scrub_ctrl
  import tmr_scrub_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 scrub_req,
  input  logic                 cfg_auto,
  input  logic [PERIOD_W-1:0]  cfg_period,
  input  logic                 usr_req,
  output logic [ADDR_W-1:0]    bank_addr,
  output logic                 bank_rd_en,
  input  logic [DATA_W-1:0]    bank_rdA,
  input  logic [DATA_W-1:0]    bank_rdB,
  input  logic [DATA_W-1:0]    bank_rdC,
  output logic                 bank_wr_en,
  output logic [DATA_W-1:0]    bank_wr_data,
  output logic                 busy,
  output logic                 done,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_flag,
  output logic [ADDR_W-1:0]    last_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  scrub_state_t        state;
  logic [PERIOD_W-1:0] timer;
  logic [DATA_W-1:0]   voted;
  logic                mismatch;
  logic                auto_en;
  logic                fire;

  tmr_majority_voter #(
    .DATA_W(DATA_W)
  ) u_voter (
    .a        (bank_rdA),
    .b        (bank_rdB),
    .c        (bank_rdC),
    .voted    (voted),
    .mismatch (mismatch)
  );

  assign auto_en = cfg_auto && (cfg_period != '0);
  assign fire    = scrub_req || (auto_en && (timer == cfg_period - PERIOD_W'(1)));

  // Strobes must drop in the very cycle a user access or reset appears,
  // so they are decoded from the registered state rather than registered.
  assign bank_rd_en = rstn && (state == READ)  && !usr_req;
  assign bank_wr_en = rstn && (state == WRITE) && !usr_req;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      timer         <= '0;
      bank_addr     <= '0;
      bank_wr_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cnt       <= '0;
      err_flag      <= 1'b0;
      last_err_addr <= '0;
    end else begin
      done <= 1'b0;
      if (err_clr) begin
        err_cnt  <= '0;
        err_flag <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fire) begin
            timer     <= '0;
            bank_addr <= '0;
            busy      <= 1'b1;
            state     <= READ;
          end else if (auto_en) begin
            timer <= timer + PERIOD_W'(1);
          end else begin
            timer <= '0;
          end
        end

        READ: begin
          if (!usr_req) state <= VOTE;
        end

        VOTE: begin
          if (mismatch) begin
            bank_wr_data  <= voted;
            // A coincident clear is applied before this correction is counted.
            err_cnt       <= sat_inc(err_clr ? {ERR_CNT_W{1'b0}} : err_cnt);
            err_flag      <= 1'b1;
            last_err_addr <= bank_addr;
            state         <= WRITE;
          end else begin
            state <= NEXT;
          end
        end

        WRITE: begin
          if (!usr_req) state <= NEXT;
        end

        NEXT: begin
          if (bank_addr == LAST_ADDR) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            bank_addr <= bank_addr + ADDR_W'(1);
            state     <= READ;
          end
        end

        DONE: begin
          busy      <= 1'b0;
          bank_addr <= '0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed bench for tmr_scrub_ctrl with a behavioural triplicated bank and a
// queue of expected voted write-backs.
module tb_tmr_scrub_ctrl;

  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int PERIOD_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic                clk = 1'b0;
  logic                rstn, scrub_req, cfg_auto, usr_req, err_clr;
  logic [PERIOD_W-1:0] cfg_period;
  logic [ADDR_W-1:0]   bank_addr, last_err_addr;
  logic                bank_rd_en, bank_wr_en, busy, done, err_flag;
  logic [DATA_W-1:0]   bank_rdA, bank_rdB, bank_rdC, bank_wr_data;
  logic [15:0]         err_cnt;

  logic [DATA_W-1:0]   mem_a [DEPTH];
  logic [DATA_W-1:0]   mem_b [DEPTH];
  logic [DATA_W-1:0]   mem_c [DEPTH];
  logic                init_en, inj_en;
  logic [ADDR_W-1:0]   inj_addr;
  logic [DATA_W-1:0]   inj_a, inj_b, inj_c;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  rd_cnt = 0;
  int  wr_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tmr_scrub_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PERIOD_W(PERIOD_W)
  ) dut (
    .clk(clk), .rstn(rstn), .scrub_req(scrub_req), .cfg_auto(cfg_auto),
    .cfg_period(cfg_period), .usr_req(usr_req), .bank_addr(bank_addr),
    .bank_rd_en(bank_rd_en), .bank_rdA(bank_rdA), .bank_rdB(bank_rdB),
    .bank_rdC(bank_rdC), .bank_wr_en(bank_wr_en), .bank_wr_data(bank_wr_data),
    .busy(busy), .done(done), .err_clr(err_clr), .err_cnt(err_cnt),
    .err_flag(err_flag), .last_err_addr(last_err_addr)
  );

  // Bank: registered read (data valid the cycle after the strobe), write to all copies.
  always @(posedge clk) begin
    if (init_en)
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= 8'(i * 17) ^ 8'h5A;
        mem_b[i] <= 8'(i * 17) ^ 8'h5A;
        mem_c[i] <= 8'(i * 17) ^ 8'h5A;
      end
    if (inj_en) begin
      mem_a[inj_addr] <= inj_a;
      mem_b[inj_addr] <= inj_b;
      mem_c[inj_addr] <= inj_c;
    end
    if (bank_wr_en) begin
      mem_a[bank_addr] <= bank_wr_data;
      mem_b[bank_addr] <= bank_wr_data;
      mem_c[bank_addr] <= bank_wr_data;
    end
    if (bank_rd_en) begin
      bank_rdA <= mem_a[bank_addr];
      bank_rdB <= mem_b[bank_addr];
      bank_rdC <= mem_c[bank_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-back scoreboard and strobe rules, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    if (bank_rd_en) rd_cnt++;
    if (bank_wr_en) begin
      wr_cnt++;
      chk("wr_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bank_addr), 32'(e.addr));
        chk("wr_data", 32'(bank_wr_data), 32'(e.data));
      end
    end
    if (bank_rd_en || bank_wr_en) begin
      chk("strobe_vs_usr", 32'(usr_req), 0);
      chk("rd_wr_excl", 32'(bank_rd_en && bank_wr_en), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic pulse(output int t);
    t = cyc;
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
  endtask

  task automatic inject(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] va,
                        input logic [DATA_W-1:0] vb, input logic [DATA_W-1:0] vc);
    inj_addr = a; inj_a = va; inj_b = vb; inj_c = vc;
    inj_en = 1'b1;
    tick();
    inj_en = 1'b0;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 600 && at < 0; i++) begin
      @(negedge clk);
      if (done) at = cyc;
    end
  endtask

  task automatic wait_busy(output int at);
    at = -1;
    for (int i = 0; i < 600 && at < 0; i++) begin
      @(negedge clk);
      if (busy) at = cyc;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},     32'(bank_addr), 0);
    chk({tag, "_rd_en"},    32'(bank_rd_en), 0);
    chk({tag, "_wr_en"},    32'(bank_wr_en), 0);
    chk({tag, "_wr_data"},  32'(bank_wr_data), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_done"},     32'(done), 0);
    chk({tag, "_err_cnt"},  32'(err_cnt), 0);
    chk({tag, "_err_flag"}, 32'(err_flag), 0);
    chk({tag, "_last_err"}, 32'(last_err_addr), 0);
  endtask

  initial begin
    int trig, at, r, b1, b2, d1, rc0, wc0;
    rstn = 1'b0; scrub_req = 1'b0; cfg_auto = 1'b0; cfg_period = '0;
    usr_req = 1'b0; err_clr = 1'b0; init_en = 1'b1; inj_en = 1'b0;
    inj_addr = '0; inj_a = '0; inj_b = '0; inj_c = '0;
    repeat (3) tick();
    init_en = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    rstn = 1'b1;
    tick();

    // Clean pass: 16 reads, no writes, done 49 cycles after trigger.
    rc0 = rd_cnt; wc0 = wr_cnt;
    pulse(trig);
    @(negedge clk);
    chk("busy_start", 32'(busy), 1);
    wait_done(at);
    chk("lat_clean", at - trig, 49);
    chk("rd_count", rd_cnt - rc0, 16);
    chk("wr_count", wr_cnt - wc0, 0);
    chk("err_cnt_clean", 32'(err_cnt), 0);
    tick();
    @(negedge clk);
    chk("busy_end", 32'(busy), 0);
    chk("done_one_cycle", 32'(done), 0);
    tick();

    // Single flipped bit in copy C at address 5.
    inject(4'd5, 8'h3C, 8'h3C, 8'h3D);
    expect_wr(4'd5, 8'h3C);
    pulse(trig);
    wait_done(at);
    chk("lat_one_err", at - trig, 50);
    chk("err_cnt_1", 32'(err_cnt), 1);
    chk("err_flag_1", 32'(err_flag), 1);
    chk("last_err_5", 32'(last_err_addr), 5);
    chk("healed_5", 32'(mem_c[5]), 32'h3C);
    tick();

    // All three copies differ at 9; write-back stalled 2 cycles by usr_req.
    inject(4'd9, 8'h0F, 8'hF0, 8'h33);
    expect_wr(4'd9, 8'h33);
    pulse(trig);
    wait_cyc(trig + 30);
    usr_req = 1'b1;
    @(negedge clk);
    chk("wr_stall_en", 32'(bank_wr_en), 0);
    chk("wr_stall_data", 32'(bank_wr_data), 32'h33);
    tick();
    tick();
    usr_req = 1'b0;
    @(negedge clk);
    chk("wr_after_stall", 32'(bank_wr_en), 1);
    wait_done(at);
    chk("lat_wr_stall", at - trig, 52);
    chk("err_cnt_2", 32'(err_cnt), 2);
    chk("last_err_9", 32'(last_err_addr), 9);
    tick();

    // Two corrections in one pass.
    inject(4'd3, 8'h11, 8'h22, 8'h22);
    inject(4'd12, 8'hA5, 8'hA5, 8'h5A);
    expect_wr(4'd3, 8'h22);
    expect_wr(4'd12, 8'hA5);
    pulse(trig);
    wait_done(at);
    chk("lat_two_err", at - trig, 51);
    chk("err_cnt_4", 32'(err_cnt), 4);
    chk("last_err_12", 32'(last_err_addr), 12);
    tick();

    // usr_req for 4 cycles while reading address 2.
    pulse(trig);
    wait_cyc(trig + 7);
    usr_req = 1'b1;
    @(negedge clk);
    chk("rd_stall_en", 32'(bank_rd_en), 0);
    chk("rd_stall_addr", 32'(bank_addr), 2);
    repeat (3) tick();
    tick();
    usr_req = 1'b0;
    @(negedge clk);
    chk("rd_after_stall", 32'(bank_rd_en), 1);
    wait_done(at);
    chk("lat_rd_stall", at - trig, 53);
    tick();

    // Counter saturation from a preloaded all-ones value.
    force dut.err_cnt = 16'hFFFF;
    tick();
    release dut.err_cnt;
    @(negedge clk);
    chk("preload_ffff", 32'(err_cnt), 32'hFFFF);
    tick();
    inject(4'd7, 8'h01, 8'h01, 8'h03);
    expect_wr(4'd7, 8'h01);
    pulse(trig);
    wait_done(at);
    chk("lat_sat", at - trig, 50);
    chk("err_cnt_sat", 32'(err_cnt), 32'hFFFF);
    tick();

    // Clear coincident with a correction at address 4 (VOTE cycle).
    inject(4'd4, 8'h80, 8'h81, 8'h80);
    expect_wr(4'd4, 8'h80);
    pulse(trig);
    wait_cyc(trig + 14);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_coinc_cnt", 32'(err_cnt), 1);
    chk("clr_coinc_flag", 32'(err_flag), 1);
    chk("last_err_4", 32'(last_err_addr), 4);
    wait_done(at);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt", 32'(err_cnt), 0);
    chk("clr_flag", 32'(err_flag), 0);
    chk("clr_keeps_addr", 32'(last_err_addr), 4);
    tick();

    // Periodic mode, period 100; a manual request mid-pass must not queue.
    rstn = 1'b0;
    cfg_auto = 1'b1;
    cfg_period = 16'd100;
    tick();
    tick();
    r = cyc;
    rstn = 1'b1;
    wait_busy(b1);
    chk("auto_first", b1 - r, 100);
    tick();
    tick();
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    wait_done(d1);
    chk("auto_lat", d1 - b1, 48);
    tick();
    wait_busy(b2);
    chk("auto_gap", b2 - d1, 101);
    cfg_auto = 1'b0;
    wait_done(at);
    tick();
    tick();

    // Reset asserted during the write-back cycle of address 6.
    inject(4'd6, 8'h55, 8'h55, 8'h54);
    pulse(trig);
    wait_cyc(trig + 21);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_wr_suppressed", 32'(bank_wr_en), 0);
    tick();
    @(negedge clk);
    chk_all_zero("rst_mid");
    rstn = 1'b1;
    tick();
    tick();
    chk("no_heal_6", 32'(mem_c[6]), 32'h54);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
